// File: rtl/pram_phase_scheduler_if.sv
// pram_phase_scheduler_if: start/finish, ipm/opm requester, MAC and PRAM DA signals of the phase scheduler
interface pram_phase_scheduler_if #(
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 10,
  parameter int OFS_WIDTH = 8,
  parameter int LAYER_W   = 4
);
  logic                 nn_start;
  logic                 nn_finish;
  logic                 busy;
  logic                 err;
  logic                 ipm_request;
  logic                 ipm_wen;
  logic [D_LEN-1:0]     ipm_din;
  logic [DA_AWIDTH-1:0] ipm_base;
  logic [OFS_WIDTH-1:0] ipm_offset;
  logic                 ipm_finish;
  logic                 ipm_enable;
  logic                 opm_request;
  logic [DA_AWIDTH-1:0] opm_base;
  logic [OFS_WIDTH-1:0] opm_offset;
  logic                 opm_finish;
  logic                 opm_enable;
  logic                 mac_start;
  logic [LAYER_W-1:0]   mac_layer;
  logic                 mac_finish;
  logic                 da_wen;
  logic [DA_AWIDTH-1:0] da_addr;
  logic [D_LEN-1:0]     da_din;
  modport slave (
    input  nn_start, ipm_request, ipm_wen, ipm_din, ipm_base, ipm_offset, ipm_finish,
           opm_request, opm_base, opm_offset, opm_finish, mac_finish,
    output nn_finish, busy, err, ipm_enable, opm_enable, mac_start, mac_layer,
           da_wen, da_addr, da_din
  );
  modport master (
    output nn_start, ipm_request, ipm_wen, ipm_din, ipm_base, ipm_offset, ipm_finish,
           opm_request, opm_base, opm_offset, opm_finish, mac_finish,
    input  nn_finish, busy, err, ipm_enable, opm_enable, mac_start, mac_layer,
           da_wen, da_addr, da_din
  );
endinterface

// File: rtl/pram_phase_scheduler.sv
// pram_phase_scheduler: sequences load -> LAYERS MAC passes -> drain over the PRAM DA port, with a watchdog
module pram_phase_scheduler #(
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 10,
  parameter int OFS_WIDTH = 8,
  parameter int LAYERS    = 3,
  parameter int LAYER_W   = 4,
  parameter int TIMEOUT   = 1024,
  parameter int TO_W      = 11
) (
  input logic                   clk,
  input logic                   rst,
  pram_phase_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, CALC, CALC_WAIT, DRAIN, DONE, ERR} state_t;
  localparam logic [TO_W-1:0]    WD_LAST    = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYERS - 1);
  state_t               r_state, w_next;
  logic [LAYER_W-1:0]   r_layer;
  logic [TO_W-1:0]      r_wd;
  logic                 r_da_wen;
  logic [DA_AWIDTH-1:0] r_da_addr;
  logic [D_LEN-1:0]     r_da_din;
  logic                 w_ipm_beat, w_opm_beat, w_act, w_counting, w_timeout;
  assign w_ipm_beat = r_state == LOAD && bus.ipm_request;
  assign w_opm_beat = r_state == DRAIN && bus.opm_request;
  assign w_act      = w_ipm_beat || w_opm_beat;
  assign w_counting = r_state inside {LOAD, CALC_WAIT, DRAIN};
  // an active request in the limit cycle counts as progress, so it never times out
  assign w_timeout  = (TIMEOUT > 0) && w_counting && !w_act && r_wd == WD_LAST;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = bus.nn_start ? LOAD : IDLE;
      LOAD:      w_next = bus.ipm_finish ? CALC : w_timeout ? ERR : LOAD;
      CALC:      w_next = CALC_WAIT;
      CALC_WAIT: w_next = bus.mac_finish ? (r_layer == LAST_LAYER ? DRAIN : CALC) :
                          w_timeout ? ERR : CALC_WAIT;
      DRAIN:     w_next = bus.opm_finish ? DONE : w_timeout ? ERR : DRAIN;
      DONE:      w_next = IDLE;
      default:   w_next = ERR;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_layer <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == CALC_WAIT && bus.mac_finish)
        r_layer <= (r_layer == LAST_LAYER) ? '0 : r_layer + 1'b1;
      if (w_next != r_state || w_act)
        r_wd <= '0;
      else if (w_counting && r_wd != '1)
        r_wd <= r_wd + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_da_wen  <= 1'b0;
      r_da_addr <= '0;
      r_da_din  <= '0;
    end else begin
      r_da_wen <= w_ipm_beat && bus.ipm_wen;
      if (w_ipm_beat) begin
        r_da_addr <= bus.ipm_base + DA_AWIDTH'(bus.ipm_offset);
        r_da_din  <= bus.ipm_din;
      end else if (w_opm_beat)
        r_da_addr <= bus.opm_base + DA_AWIDTH'(bus.opm_offset);
    end
  end
  assign bus.nn_finish  = r_state == DONE;
  assign bus.busy       = r_state != IDLE;
  assign bus.err        = r_state == ERR;
  assign bus.ipm_enable = r_state == LOAD;
  assign bus.opm_enable = r_state == DRAIN;
  assign bus.mac_start  = r_state == CALC;
  assign bus.mac_layer  = r_layer;
  assign bus.da_wen     = r_da_wen;
  assign bus.da_addr    = r_da_addr;
  assign bus.da_din     = r_da_din;
endmodule

// File: doc/pram_phase_scheduler.md
Name: pram_phase_scheduler

Overview:
- Top-level sequencer for one inference pass over the shared parameter RAM (PRAM) activation bank.
- Grants the PRAM port to the input processing module (ipm) for loading.
- Steps the MAC engine through LAYERS layers, then grants the port to the output processing module (opm) for draining.
- Owns the PRAM DA write/address mux. Also runs a watchdog so a stuck requester raises a sticky error instead of hanging the pass.

Parameters:
- D_LEN, 16, PRAM data word width.
- DA_AWIDTH, 10, PRAM activation address width.
- OFS_WIDTH, 8, requester offset width (OFS_WIDTH <= DA_AWIDTH).
- LAYERS, 3, number of MAC layer passes per inference (>=1).
- LAYER_W, 4, width of the layer index (2^LAYER_W >= LAYERS).
- TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog.
- TO_W, 11, watchdog counter width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- nn_start  in  1  start one pass; sampled only in IDLE.
- nn_finish  out  1  one-cycle pulse when the pass completes.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error; cleared only by rst.
- ipm_request  in  1  ipm has a valid beat.
- ipm_wen  in  1  ipm beat is a write.
- ipm_din  in  D_LEN  ipm write data.
- ipm_base  in  DA_AWIDTH  ipm base address.
- ipm_offset  in  OFS_WIDTH  ipm offset.
- ipm_finish  in  1  ipm load complete.
- ipm_enable  out  1  ipm owns PRAM.
- opm_request  in  1  opm has a valid read beat.
- opm_base  in  DA_AWIDTH  opm base address.
- opm_offset  in  OFS_WIDTH  opm offset.
- opm_finish  in  1  opm drain complete.
- opm_enable  out  1  opm owns PRAM.
- mac_start  out  1  one-cycle pulse to start a layer.
- mac_layer  out  LAYER_W  current layer index.
- mac_finish  in  1  MAC layer done.
- da_wen  out  1  PRAM DA write enable.
- da_addr  out  DA_AWIDTH  PRAM DA address.
- da_din  out  D_LEN  PRAM DA write data.

Behaviour:

Reset values:
- rst asserted forces, immediately and asynchronously: state=IDLE, layer_cnt=0, wd_cnt=0.
- All outputs are 0: nn_finish, busy, err, ipm_enable, opm_enable, mac_start, mac_layer, da_wen, da_addr, da_din.

States: IDLE, LOAD, CALC, CALC_WAIT, DRAIN, DONE, ERR.

State transitions:
- IDLE: nn_start -> LOAD. nn_start in any other state is ignored.
- LOAD:
  - ipm_enable=1 (combinational from state).
  - Each cycle with ipm_request=1, registered outputs next cycle: da_addr = ipm_base + zero-extended ipm_offset, modulo 2^DA_AWIDTH (wraps, no carry out); da_din = ipm_din; da_wen = ipm_wen.
  - ipm_request=0 -> da_wen=0 next cycle.
  - ipm_finish -> CALC. A beat presented in the same cycle as ipm_finish is still written.
- CALC: mac_start=1 for exactly this one cycle; mac_layer = layer_cnt. Always -> CALC_WAIT. mac_finish sampled in CALC is ignored.
- CALC_WAIT:
  - mac_finish with layer_cnt==LAYERS-1 -> DRAIN, and layer_cnt clears to 0.
  - Otherwise mac_finish -> layer_cnt+1 -> CALC.
  - mac_layer holds its value throughout.
- DRAIN:
  - opm_enable=1; da_wen held 0.
  - opm_request=1 -> da_addr = opm_base + zero-extended opm_offset, registered with 1-cycle latency and the same wrap rule.
  - opm_finish -> DONE.
- DONE: nn_finish=1 for one cycle -> IDLE.
- ERR: all enables, mac_start and da_wen are 0; err=1. Remains in ERR until rst.

Exclusivity:
- ipm_enable and opm_enable are never high in the same cycle.
- da_wen is never 1 outside LOAD plus the single trailing cycle after LOAD.

Watchdog (TIMEOUT>0):
- wd_cnt clears on every state entry, and in LOAD/DRAIN on any cycle with the owner's request high.
- Otherwise it increments in LOAD, CALC_WAIT and DRAIN.
- wd_cnt==TIMEOUT-1 with no finish that cycle -> ERR, err=1.
- finish and timeout in the same cycle: finish wins.
- wd_cnt saturates and does not wrap.

Test Plan:
1. rst=1 mid-DRAIN with opm_enable=1 -> same-cycle opm_enable=0, busy=0. After release, nn_start runs a full pass normally.
2. Nominal pass, LAYERS=3: nn_start, 4 ipm writes (base=0x3F0, offsets 0..3), ipm_finish, then mac_finish 5 cycles after each mac_start, then opm_finish.
   - da_wen=1 at addresses 0x3F0..0x3F3 with 1-cycle latency.
   - mac_start pulses exactly 3 times with mac_layer=0,1,2.
   - nn_finish pulses once; busy returns to 0.
3. Address wrap: ipm_base=0x3FF, ipm_offset=0x02 -> da_addr=0x001.
4. Ignored events:
   - nn_start during CALC_WAIT -> no effect.
   - mac_finish asserted in the CALC cycle -> no layer advance; the advance happens only on the later CALC_WAIT mac_finish.
5. Watchdog, TIMEOUT=16: mac_finish withheld -> err=1 and state=ERR after 16 cycles in CALC_WAIT; all enables 0; only rst clears err.
6. Watchdog race: opm_finish arrives in the exact timeout cycle -> DONE, nn_finish=1, err stays 0.
